// File: rtl/noc_credit_ctrl_if.sv
// Flit/credit handshake bundle between the switch allocator, the credit controller and the output links.
// The master side offers flits and returns credits; the slave side is the credit controller.
interface noc_credit_ctrl_if #(
  parameter int unsigned NumPorts     = 5,
  parameter int unsigned CreditsWidth = 3
);
  logic [NumPorts-1:0]              flit_valid;
  logic [NumPorts-1:0]              flit_head;
  logic [NumPorts-1:0]              flit_tail;
  logic [NumPorts-1:0]              credit_ret;
  logic [NumPorts-1:0]              flit_send;
  logic [NumPorts*CreditsWidth-1:0] credits;
  logic [NumPorts-1:0]              credits_low;
  logic [NumPorts-1:0]              port_locked;
  logic [NumPorts-1:0]              err;

  modport master (
    output flit_valid, flit_head, flit_tail, credit_ret,
    input  flit_send, credits, credits_low, port_locked, err
  );

  modport slave (
    input  flit_valid, flit_head, flit_tail, credit_ret,
    output flit_send, credits, credits_low, port_locked, err
  );
endinterface

// File: rtl/noc_credit_ctrl.sv
// Per-output-port credit / ack-nack flow control with wormhole packet lock tracking.
// Optional macro NOC_CREDIT_LOOKAHEAD_EN: a credit returning this cycle may be spent this cycle.
package noc_credit_pkg;
  typedef enum logic {
    kFlowControlCreditBased = 1'b0,
    kFlowControlAckNack     = 1'b1
  } flow_control_e;
endpackage

module noc_credit_ctrl
  import noc_credit_pkg::*;
#(
  parameter int unsigned   NumPorts     = 5,
  parameter int unsigned   QueueDepth   = 5,
  parameter int unsigned   CreditsWidth = $clog2(QueueDepth + 1),
  parameter flow_control_e FlowControl  = kFlowControlCreditBased,
  parameter int unsigned   LowThreshold = 1
) (
  input logic              clk,
  input logic              rst,
  noc_credit_ctrl_if.slave bus
);

  typedef enum logic {
    LockIdle = 1'b0,
    LockBusy = 1'b1
  } lock_state_e;

  localparam logic [CreditsWidth-1:0] Full    = CreditsWidth'(QueueDepth);
  localparam logic [CreditsWidth:0]   FullExt = (CreditsWidth + 1)'(QueueDepth);

  logic                    run_q;
  logic [CreditsWidth-1:0] credit_q [NumPorts];
  logic [CreditsWidth-1:0] credit_d [NumPorts];
  logic [CreditsWidth:0]   sum      [NumPorts];
  lock_state_e             state_q  [NumPorts];
  lock_state_e             state_d  [NumPorts];
  logic [NumPorts-1:0]     err_q;
  logic [NumPorts-1:0]     err_d;
  logic [NumPorts-1:0]     send;

  // Launch decision; held off until the first edge after reset release.
  always_comb begin
    send = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (FlowControl == kFlowControlAckNack) begin
        send[p] = run_q & bus.flit_valid[p] & bus.credit_ret[p];
      end else begin
`ifdef NOC_CREDIT_LOOKAHEAD_EN
        send[p] = run_q & bus.flit_valid[p] & ((credit_q[p] != '0) | bus.credit_ret[p]);
`else
        send[p] = run_q & bus.flit_valid[p] & (credit_q[p] != '0);
`endif
      end
    end
  end

  // NOTE: every variable gets a default before any branch, otherwise always_comb infers a latch.
  always_comb begin
    err_d = err_q;
    for (int p = 0; p < NumPorts; p++) begin
      credit_d[p] = credit_q[p];
      state_d[p]  = state_q[p];
      sum[p]      = {1'b0, credit_q[p]} - (CreditsWidth + 1)'(send[p])
                    + (CreditsWidth + 1)'(bus.credit_ret[p]);

      if (FlowControl == kFlowControlAckNack) begin
        credit_d[p] = Full;
      end else if (sum[p] > FullExt) begin
        credit_d[p] = Full;
        err_d[p]    = 1'b1;
      end else begin
        credit_d[p] = sum[p][CreditsWidth-1:0];
      end

      if (send[p]) begin
        unique case (state_q[p])
          LockIdle: begin
            if (!bus.flit_head[p])     err_d[p]   = 1'b1;
            else if (!bus.flit_tail[p]) state_d[p] = LockBusy;
          end
          LockBusy: begin
            if (bus.flit_head[p]) err_d[p]   = 1'b1;
            if (bus.flit_tail[p]) state_d[p] = LockIdle;
          end
          default: state_d[p] = LockIdle;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
      err_q <= '0;
      // NOTE: this per-port array is a handful of flops, not a RAM, so it is reset like any register.
      for (int p = 0; p < NumPorts; p++) begin
        credit_q[p] <= Full;
        state_q[p]  <= LockIdle;
      end
    end else begin
      run_q <= 1'b1;
      err_q <= err_d;
      for (int p = 0; p < NumPorts; p++) begin
        credit_q[p] <= credit_d[p];
        state_q[p]  <= state_d[p];
      end
    end
  end

  always_comb begin
    bus.flit_send   = send;
    bus.err         = err_q;
    bus.credits     = '0;
    bus.credits_low = '0;
    bus.port_locked = '0;
    for (int p = 0; p < NumPorts; p++) begin
      bus.credits[p*CreditsWidth +: CreditsWidth] = credit_q[p];
      bus.port_locked[p] = (state_q[p] == LockBusy);
      if (FlowControl == kFlowControlCreditBased) begin
        bus.credits_low[p] = (32'(credit_q[p]) <= LowThreshold);
      end
    end
  end

endmodule
